wb_intercon_reg: RTL and testbench
==================================

Name: wb_intercon_reg

Overview:
Registered, parametrised single-master Wishbone interconnect and the successor to the combinational page decoder. It decodes a master request against NS mask/base windows and forwards it to exactly one slave through a registered request stage. It adds default-slave error responses for unmapped addresses and an optional bus-timeout watchdog. It sits between the management core's Wishbone master and the RAM, flash, UART, GPIO, system-control and flash-config slaves.

Parameters:
DW, 32, data width; must be a multiple of 8.
AW, 32, address width.
NS, 6, number of slaves.
ADR_MASK, NS*AW bits, per-slave decode mask; default is 8'hFF in the top byte for all six slots.
SLAVE_ADR, NS*AW bits, per-slave base; default slots 0..5 = 0x0000_0000, 0x1000_0000, 0x2000_0000, 0x2100_0000, 0x2200_0000, 0x2800_0000.
TO_W, 8, timeout counter width.
TIMEOUT, 255, number of ACCESS cycles before forced error; range 1 to 2^TO_W-1.
ERR_DATA, 32'hDEAD_BEEF, read data returned on any error response (DW bits).

Ports:
clk  in  1  system clock; all logic on rising edge.
resetn  in  1  asynchronous, active-low reset.
wbm_cyc_i  in  1  master cycle.
wbm_stb_i  in  1  master strobe.
wbm_we_i  in  1  master write enable.
wbm_sel_i  in  DW/8  byte selects.
wbm_adr_i  in  AW  address.
wbm_dat_i  in  DW  write data.
wbm_dat_o  out  DW  registered read data.
wbm_ack_o  out  1  one-cycle acknowledge; successful or error.
wbm_err_o  out  1  qualifies wbm_ack_o as an error (unmapped or timeout).
wbs_cyc_o  out  NS  per-slave cycle (one-hot).
wbs_stb_o  out  NS  per-slave strobe (one-hot).
wbs_we_o  out  1  latched write enable, shared by all slaves.
wbs_sel_o  out  DW/8  latched byte selects, shared.
wbs_adr_o  out  AW  latched address, shared.
wbs_dat_o  out  DW  latched write data, shared.
wbs_dat_i  in  NS*DW  slave read data; slot i at bits [(i+1)*DW-1 : i*DW].
wbs_ack_i  in  NS  slave acknowledges.
busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (resetn low, asynchronous): FSM goes to IDLE. wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o and busy_o are 0. wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_sel_o and wbs_we_o are 0. Timeout counter is 0.
- Reset asserted mid-transaction: in-flight access is dropped and no ack is issued.
- Decode: hit[i] = ((wbm_adr_i & MASK_i) == BASE_i). If several slots hit, the lowest index wins (one-hot result).
- IDLE:
  - On cyc&stb, latch adr, dat, sel, we and the one-hot select.
  - Hit: go to ACCESS.
  - No hit: go to RESP with err=1 and data=ERR_DATA. No slave is strobed.
- ACCESS:
  - wbs_cyc_o and wbs_stb_o equal the latched one-hot select.
  - Only the selected slave's ack is observed; acks from other slaves are ignored.
  - Selected ack: capture that slave's wbs_dat_i into wbm_dat_o, go to RESP with err=0.
  - Master drops wbm_cyc_i: abort, deassert slave strobes, return to IDLE, no ack.
  - Simultaneous ack and cyc drop: the abort wins.
- RESP:
  - wbm_ack_o=1 for exactly one cycle; wbm_err_o valid in the same cycle.
  - Slave strobes are already deasserted.
  - Next state is IDLE.
  - The master is required to drop stb after ack (classic Wishbone). The IDLE state after RESP therefore does not re-accept the same request, because the request is re-evaluated only on the following cycle's inputs.
- Latency: request seen at edge N, slave strobe in cycle N+1. A zero-wait slave acking in N+1 produces master ack in N+2. An unmapped access acks in N+1.
- wbm_dat_o holds its last captured value between transactions. On write transactions it is don't-care.

Optional Feature:
Macro WB_INTERCON_TIMEOUT_EN.
- Defined:
  - The counter increments every ACCESS cycle and clears on entering ACCESS.
  - When the count reaches TIMEOUT with no ack, slave strobes drop, the FSM goes to RESP with err=1 and data=ERR_DATA.
  - An ack arriving in the same cycle as the timeout wins (normal response).
- Undefined: no counter is present; ACCESS waits indefinitely for an ack or a cyc drop.

Decomposition:
Shared package wb_intercon_pkg:
- FSM state encoding (IDLE, ACCESS, RESP).
- Default ADR_MASK and SLAVE_ADR memory-map constants.
- Default ERR_DATA.

One sub-module, wb_addr_decode: combinational mask/base compare with lowest-index priority, producing the one-hot select and a hit flag. It is parametrised by AW, NS, ADR_MASK and SLAVE_ADR.

Test Plan:
1. Read 0x2000_0010 with UART slot (2) acking in its first strobe cycle and returning 0x1234_5678 -> wbs_stb_o=6'b000100 at N+1; wbm_ack_o=1, wbm_err_o=0 and wbm_dat_o=0x1234_5678 at N+2.
2. Write 0x2100_0004 with data 0xA5A5_A5A5 and sel=4'b0011 -> wbs_adr_o, wbs_dat_o and wbs_sel_o latched exactly; only slot 3 is strobed; one-cycle ack.
3. Access unmapped 0x3000_0000 -> no wbs_stb_o bit ever rises; at N+1 wbm_ack_o=1, wbm_err_o=1 and wbm_dat_o=0xDEAD_BEEF.
4. Timeout (WB_INTERCON_TIMEOUT_EN defined, TIMEOUT=4), slot 5 never acks, while slot 0 asserts ack throughout -> slot 0 ack is ignored; strobe lasts 4 cycles; then error ack with 0xDEAD_BEEF.
5. Master drops cyc in the 2nd ACCESS cycle; separately, resetn pulsed low mid-ACCESS -> in both cases strobes clear, FSM returns to IDLE with busy_o=0, and no wbm_ack_o is produced.

Source files
------------

// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the registered Wishbone interconnect: FSM encoding,
// the default six-slot memory map and the error read-data word.
package wb_intercon_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int DEF_NS = 6;
    localparam int DEF_AW = 32;

    // Slot order from bit 0 upward: RAM, flash, UART, GPIO, sysctrl, flash-config.
    localparam logic [DEF_NS*DEF_AW-1:0] DEF_ADR_MASK = {DEF_NS{32'hFF00_0000}};
    localparam logic [DEF_NS*DEF_AW-1:0] DEF_SLAVE_ADR = {
        32'h2800_0000,
        32'h2200_0000,
        32'h2100_0000,
        32'h2000_0000,
        32'h1000_0000,
        32'h0000_0000
    };

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational mask/base address decoder; when several windows match,
// the lowest slot index wins so the select is always one-hot or zero.
module wb_addr_decode
    import wb_intercon_pkg::*;
#(
    parameter int                  AW        = 32,
    parameter int                  NS        = 6,
    parameter logic [NS*AW-1:0]    ADR_MASK  = DEF_ADR_MASK,
    parameter logic [NS*AW-1:0]    SLAVE_ADR = DEF_SLAVE_ADR
) (
    input  logic [AW-1:0] i_adr,
    output logic [NS-1:0] o_sel,
    output logic          o_hit
);

    always_comb begin
        o_sel = '0;
        o_hit = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!o_hit && ((i_adr & ADR_MASK[i*AW +: AW]) == SLAVE_ADR[i*AW +: AW])) begin
                o_sel[i] = 1'b1;
                o_hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_intercon_reg.sv
// Registered single-master Wishbone interconnect with default-slave errors.
// Define WB_INTERCON_TIMEOUT_EN to add the ACCESS-state bus-timeout watchdog.
module wb_intercon_reg
    import wb_intercon_pkg::*;
#(
    parameter int               DW        = 32,
    parameter int               AW        = 32,
    parameter int               NS        = 6,
    parameter logic [NS*AW-1:0] ADR_MASK  = DEF_ADR_MASK,
    parameter logic [NS*AW-1:0] SLAVE_ADR = DEF_SLAVE_ADR,
    parameter int               TO_W      = 8,
    parameter int               TIMEOUT   = 255,
    parameter logic [DW-1:0]    ERR_DATA  = DW'(DEF_ERR_DATA)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wbm_cyc_i,
    input  logic              wbm_stb_i,
    input  logic              wbm_we_i,
    input  logic [DW/8-1:0]   wbm_sel_i,
    input  logic [AW-1:0]     wbm_adr_i,
    input  logic [DW-1:0]     wbm_dat_i,
    output logic [DW-1:0]     wbm_dat_o,
    output logic              wbm_ack_o,
    output logic              wbm_err_o,
    output logic [NS-1:0]     wbs_cyc_o,
    output logic [NS-1:0]     wbs_stb_o,
    output logic              wbs_we_o,
    output logic [DW/8-1:0]   wbs_sel_o,
    output logic [AW-1:0]     wbs_adr_o,
    output logic [DW-1:0]     wbs_dat_o,
    input  logic [NS*DW-1:0]  wbs_dat_i,
    input  logic [NS-1:0]     wbs_ack_i,
    output logic              busy_o
);

    if ((DW % 8) != 0) begin : g_bad_dw
        $error("wb_intercon_reg: DW must be a multiple of 8");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > ((1 << TO_W) - 1))) begin : g_bad_timeout
        $error("wb_intercon_reg: TIMEOUT out of range for TO_W");
    end

    logic [1:0]      r_state;
    logic [NS-1:0]   r_slv;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_wdat;
    logic [DW/8-1:0] r_sel;
    logic            r_we;
    logic [DW-1:0]   r_rdat;
    logic            r_err;

    logic [NS-1:0]   w_sel;
    logic            w_hit;
    logic            w_ack;
    logic [DW-1:0]   w_rdat;
    logic            w_timeout;

    wb_addr_decode #(
        .AW        (AW),
        .NS        (NS),
        .ADR_MASK  (ADR_MASK),
        .SLAVE_ADR (SLAVE_ADR)
    ) u_decode (
        .i_adr (wbm_adr_i),
        .o_sel (w_sel),
        .o_hit (w_hit)
    );

    // Acks and read data from unselected slots are masked off by the latched select.
    assign w_ack = |(wbs_ack_i & r_slv);

    always_comb begin
        w_rdat = '0;
        for (int i = 0; i < NS; i++) begin
            if (r_slv[i]) begin
                w_rdat = w_rdat | wbs_dat_i[i*DW +: DW];
            end
        end
    end

`ifdef WB_INTERCON_TIMEOUT_EN
    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state != ST_ACCESS) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th ACCESS cycle so the strobe lasts exactly TIMEOUT cycles.
    assign w_timeout = (r_state == ST_ACCESS) && (r_cnt == TO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_slv   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_rdat  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        r_adr  <= wbm_adr_i;
                        r_wdat <= wbm_dat_i;
                        r_sel  <= wbm_sel_i;
                        r_we   <= wbm_we_i;
                        r_slv  <= w_sel;
                        if (w_hit) begin
                            r_state <= ST_ACCESS;
                        end else begin
                            r_state <= ST_RESP;
                            r_err   <= 1'b1;
                            r_rdat  <= ERR_DATA;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Abort beats ack, and ack beats the watchdog.
                    if (!wbm_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_ack) begin
                        r_state <= ST_RESP;
                        r_err   <= 1'b0;
                        r_rdat  <= w_rdat;
                    end else if (w_timeout) begin
                        r_state <= ST_RESP;
                        r_err   <= 1'b1;
                        r_rdat  <= ERR_DATA;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbs_cyc_o = (r_state == ST_ACCESS) ? r_slv : '0;
    assign wbs_stb_o = (r_state == ST_ACCESS) ? r_slv : '0;
    assign wbs_we_o  = r_we;
    assign wbs_sel_o = r_sel;
    assign wbs_adr_o = r_adr;
    assign wbs_dat_o = r_wdat;

    assign wbm_ack_o = (r_state == ST_RESP);
    assign wbm_err_o = (r_state == ST_RESP) && r_err;
    assign wbm_dat_o = r_rdat;
    assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_intercon_reg.sv
// Self-checking bench for wb_intercon_reg using a response scoreboard.
// With WB_INTERCON_TIMEOUT_EN defined the DUT is built with TIMEOUT=4.
module tb_wb_intercon_reg;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NS   = 6;
    localparam int SW   = DW / 8;
    localparam int TO_W = 8;
`ifdef WB_INTERCON_TIMEOUT_EN
    localparam int TIMEOUT = 4;
`else
    localparam int TIMEOUT = 255;
`endif
    localparam logic [DW-1:0] ERR_WORD = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             wbm_cyc_i = 1'b0;
    logic             wbm_stb_i = 1'b0;
    logic             wbm_we_i = 1'b0;
    logic [SW-1:0]    wbm_sel_i = '0;
    logic [AW-1:0]    wbm_adr_i = '0;
    logic [DW-1:0]    wbm_dat_i = '0;
    logic [DW-1:0]    wbm_dat_o;
    logic             wbm_ack_o;
    logic             wbm_err_o;
    logic [NS-1:0]    wbs_cyc_o;
    logic [NS-1:0]    wbs_stb_o;
    logic             wbs_we_o;
    logic [SW-1:0]    wbs_sel_o;
    logic [AW-1:0]    wbs_adr_o;
    logic [DW-1:0]    wbs_dat_o;
    logic [NS*DW-1:0] wbs_dat_i = '0;
    logic [NS-1:0]    wbs_ack_i = '0;
    logic             busy_o;

    typedef struct packed {
        logic          err;
        logic          chkData;
        logic [DW-1:0] data;
    } resp_t;

    resp_t expQ[$];
    int    nVectors = 0;
    int    nMiscompares = 0;

    wb_intercon_reg #(
        .DW      (DW),
        .AW      (AW),
        .NS      (NS),
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] slotWord(input int slot, input int k);
        return DW'(32'h5000_0000 + slot * 32'h0010_0000 + k);
    endfunction

    task automatic loadSlaveData(input int k);
        for (int i = 0; i < NS; i++) begin
            wbs_dat_i[i*DW +: DW] = slotWord(i, k);
        end
    endtask

    task automatic startReq(input logic [AW-1:0] adr, input logic we,
                            input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        wbm_adr_i = adr;
        wbm_we_i  = we;
        wbm_dat_i = dat;
        wbm_sel_i = sel;
    endtask

    task automatic endReq();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        startReq(32'h2000_0000, 1'b1, 32'hFFFF_FFFF, '1);
        wbs_ack_i = '1;
        #22;
        nVectors++;
        if ({wbm_ack_o, wbm_err_o, busy_o, wbs_we_o, wbs_cyc_o, wbs_stb_o} !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_ctrl: got ack=%b err=%b busy=%b we=%b cyc=%b stb=%b, want all 0",
                     wbm_ack_o, wbm_err_o, busy_o, wbs_we_o, wbs_cyc_o, wbs_stb_o);
        end
        nVectors++;
        if ({wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_sel_o} !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_data: got rdat=%h adr=%h wdat=%h sel=%b, want all 0",
                     wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_sel_o);
        end
        endReq();
        wbs_ack_i = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        nVectors++;
        if (busy_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_release_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_read();
        resp_t expItem;
        loadSlaveData(1);
        wbs_dat_i[2*DW +: DW] = 32'h1234_5678;
        startReq(32'h2000_0010, 1'b0, '0, '1);
        expQ.push_back('{err: 1'b0, chkData: 1'b1, data: 32'h1234_5678});
        @(posedge clk);
        #1;
        nVectors++;
        if (wbs_stb_o !== 6'b000100 || wbs_cyc_o !== 6'b000100 || wbm_ack_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL read_strobe: got stb=%b cyc=%b ack=%b want stb=cyc=000100 ack=0",
                     wbs_stb_o, wbs_cyc_o, wbm_ack_o);
        end
        wbs_ack_i = 6'b000100;
        @(posedge clk);
        #1;
        wbs_ack_i = '0;
        nVectors++;
        if (wbm_ack_o !== 1'b1 || wbs_stb_o !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL read_ack: got ack=%b stb=%b want ack=1 stb=0", wbm_ack_o, wbs_stb_o);
        end
        expItem = expQ.pop_front();
        nVectors++;
        if (wbm_err_o !== expItem.err || wbm_dat_o !== expItem.data) begin
            nMiscompares++;
            $display("[TB] FAIL read_data: got err=%b dat=%h want err=%b dat=%h",
                     wbm_err_o, wbm_dat_o, expItem.err, expItem.data);
        end
        endReq();
        @(posedge clk);
        #1;
        nVectors++;
        if (wbm_ack_o !== 1'b0 || busy_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL read_ack_width: got ack=%b busy=%b want 0 0", wbm_ack_o, busy_o);
        end
    endtask

    task automatic test_write();
        resp_t expItem;
        startReq(32'h2100_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011);
        expQ.push_back('{err: 1'b0, chkData: 1'b0, data: '0});
        @(posedge clk);
        #1;
        endReq();
        wbm_cyc_i = 1'b1;
        nVectors++;
        if (wbs_stb_o !== 6'b001000 || wbs_adr_o !== 32'h2100_0004 || wbs_dat_o !== 32'hA5A5_A5A5
            || wbs_sel_o !== 4'b0011 || wbs_we_o !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL write_latch: got stb=%b adr=%h dat=%h sel=%b we=%b want 001000 21000004 a5a5a5a5 0011 1",
                     wbs_stb_o, wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o);
        end
        @(posedge clk);
        #1;
        nVectors++;
        if (wbs_stb_o !== 6'b001000 || wbm_ack_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL write_wait: got stb=%b ack=%b want 001000 0", wbs_stb_o, wbm_ack_o);
        end
        wbs_ack_i = 6'b001000;
        @(posedge clk);
        #1;
        wbs_ack_i = '0;
        expItem = expQ.pop_front();
        nVectors++;
        if (wbm_ack_o !== 1'b1 || wbm_err_o !== expItem.err) begin
            nMiscompares++;
            $display("[TB] FAIL write_ack: got ack=%b err=%b want 1 %b", wbm_ack_o, wbm_err_o, expItem.err);
        end
        endReq();
        @(posedge clk);
        #1;
        nVectors++;
        if (wbm_ack_o !== 1'b0 || wbs_stb_o !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL write_ack_width: got ack=%b stb=%b want 0 0", wbm_ack_o, wbs_stb_o);
        end
    endtask

    task automatic test_unmapped();
        resp_t expItem;
        startReq(32'h3000_0000, 1'b0, '0, '1);
        expQ.push_back('{err: 1'b1, chkData: 1'b1, data: ERR_WORD});
        @(posedge clk);
        #1;
        expItem = expQ.pop_front();
        nVectors++;
        if (wbm_ack_o !== 1'b1 || wbs_stb_o !== '0 || wbs_cyc_o !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL unmapped_ack: got ack=%b stb=%b cyc=%b want 1 0 0", wbm_ack_o, wbs_stb_o, wbs_cyc_o);
        end
        nVectors++;
        if (wbm_err_o !== expItem.err || wbm_dat_o !== expItem.data) begin
            nMiscompares++;
            $display("[TB] FAIL unmapped_err: got err=%b dat=%h want %b %h",
                     wbm_err_o, wbm_dat_o, expItem.err, expItem.data);
        end
        endReq();
        @(posedge clk);
        #1;
        nVectors++;
        if (wbm_ack_o !== 1'b0 || wbs_stb_o !== '0 || busy_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL unmapped_after: got ack=%b stb=%b busy=%b want 0", wbm_ack_o, wbs_stb_o, busy_o);
        end
    endtask

    task automatic test_timeout();
        resp_t expItem;
        int    stbCycles = 0;
        bit    gotAck = 0;
        bit    badStb = 0;
        loadSlaveData(3);
        startReq(32'h2800_0000, 1'b0, '0, '1);
        wbs_ack_i = 6'b000001;
`ifdef WB_INTERCON_TIMEOUT_EN
        expQ.push_back('{err: 1'b1, chkData: 1'b1, data: ERR_WORD});
        for (int c = 0; c < 20 && !gotAck; c++) begin
            @(posedge clk);
            #1;
            if (wbm_ack_o) begin
                gotAck = 1;
                expItem = expQ.pop_front();
                nVectors++;
                if (wbm_err_o !== expItem.err || wbm_dat_o !== expItem.data || wbs_stb_o !== '0) begin
                    nMiscompares++;
                    $display("[TB] FAIL timeout_resp: got err=%b dat=%h stb=%b want %b %h 0",
                             wbm_err_o, wbm_dat_o, wbs_stb_o, expItem.err, expItem.data);
                end
            end else if (wbs_stb_o === 6'b100000) begin
                stbCycles++;
            end else begin
                badStb = 1;
            end
        end
        nVectors++;
        if (!gotAck) begin
            nMiscompares++;
            expQ.delete();
            $display("[TB] FAIL timeout_ack: no ack within 20 cycles, want error ack");
        end
        nVectors++;
        if (stbCycles != TIMEOUT || badStb) begin
            nMiscompares++;
            $display("[TB] FAIL timeout_len: got %0d strobe cycles (bad=%0d) want %0d", stbCycles, badStb, TIMEOUT);
        end
`else
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (wbm_ack_o !== 1'b0) gotAck = 1;
            if (wbs_stb_o === 6'b100000) stbCycles++;
            else badStb = 1;
        end
        nVectors++;
        if (gotAck || badStb || stbCycles != 30) begin
            nMiscompares++;
            $display("[TB] FAIL wait_forever: got ack=%0d bad=%0d strobe cycles=%0d want 0 0 30",
                     gotAck, badStb, stbCycles);
        end
`endif
        wbs_ack_i = '0;
        endReq();
        @(posedge clk);
        #1;
        nVectors++;
        if (busy_o !== 1'b0 || wbs_stb_o !== '0 || wbm_ack_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL timeout_idle: got busy=%b stb=%b ack=%b want 0", busy_o, wbs_stb_o, wbm_ack_o);
        end
    endtask

    task automatic test_abort();
        bit sawAck = 0;
        loadSlaveData(4);
        startReq(32'h0000_0100, 1'b0, '0, '1);
        @(posedge clk);
        #1;
        nVectors++;
        if (wbs_stb_o !== 6'b000001) begin
            nMiscompares++;
            $display("[TB] FAIL abort_strobe: got %b want 000001", wbs_stb_o);
        end
        @(posedge clk);
        #1;
        endReq();
        wbs_ack_i = 6'b000001;
        @(posedge clk);
        #1;
        wbs_ack_i = '0;
        nVectors++;
        if (wbs_stb_o !== '0 || busy_o !== 1'b0 || wbm_ack_o !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL abort_idle: got stb=%b busy=%b ack=%b want 0", wbs_stb_o, busy_o, wbm_ack_o);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (wbm_ack_o !== 1'b0) sawAck = 1;
        end
        nVectors++;
        if (sawAck) begin
            nMiscompares++;
            $display("[TB] FAIL abort_no_ack: got late ack=1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        bit sawAck = 0;
        startReq(32'h2200_0000, 1'b1, 32'h0BAD_F00D, '1);
        @(posedge clk);
        #1;
        nVectors++;
        if (wbs_stb_o !== 6'b010000 || busy_o !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL rstmid_strobe: got stb=%b busy=%b want 010000 1", wbs_stb_o, busy_o);
        end
        #2;
        resetn = 1'b0;
        #1;
        nVectors++;
        if (wbs_stb_o !== '0 || wbs_cyc_o !== '0 || busy_o !== 1'b0 || wbs_adr_o !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL rstmid_clear: got stb=%b cyc=%b busy=%b adr=%h want all 0",
                     wbs_stb_o, wbs_cyc_o, busy_o, wbs_adr_o);
        end
        endReq();
        wbs_ack_i = 6'b010000;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (wbm_ack_o !== 1'b0 || busy_o !== 1'b0) sawAck = 1;
        end
        wbs_ack_i = '0;
        nVectors++;
        if (sawAck) begin
            nMiscompares++;
            $display("[TB] FAIL rstmid_no_ack: ack or busy rose after reset, want 0");
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] tblAdr [10];
        int            tblSlot[10];
        resp_t         expItem;
        logic [NS-1:0] expStb;
        logic [NS-1:0] seenStb;
        int            latency;
        tblAdr  = '{32'h0000_0000, 32'h00FF_FFFC, 32'h1000_0040, 32'h20FF_FFFC, 32'h2100_0000,
                    32'h2200_0010, 32'h2800_0008, 32'h2300_0000, 32'hFF00_0000, 32'h2900_0000};
        tblSlot = '{0, 0, 1, 2, 3, 4, 5, -1, -1, -1};
        for (int k = 0; k < 10; k++) begin
            loadSlaveData(k + 10);
            if (tblSlot[k] < 0) begin
                expQ.push_back('{err: 1'b1, chkData: 1'b1, data: ERR_WORD});
                expStb = '0;
            end else begin
                expQ.push_back('{err: 1'b0, chkData: 1'b1, data: slotWord(tblSlot[k], k + 10)});
                expStb = NS'(1) << tblSlot[k];
            end
            startReq(tblAdr[k], 1'b0, '0, '1);
            seenStb = '0;
            latency = 0;
            for (int c = 0; c < 10 && latency == 0; c++) begin
                @(posedge clk);
                #1;
                wbs_ack_i = '0;
                if (wbm_ack_o === 1'b1) begin
                    latency = c + 1;
                    expItem = expQ.pop_front();
                    nVectors++;
                    if (wbm_err_o !== expItem.err || (expItem.chkData && wbm_dat_o !== expItem.data)) begin
                        nMiscompares++;
                        $display("[TB] FAIL b2b_resp[%0d]: got err=%b dat=%h want %b %h",
                                 k, wbm_err_o, wbm_dat_o, expItem.err, expItem.data);
                    end
                end else if (wbs_stb_o !== '0) begin
                    seenStb   = seenStb | wbs_stb_o;
                    wbs_ack_i = wbs_stb_o;
                end
            end
            wbs_ack_i = '0;
            endReq();
            nVectors++;
            if (latency != ((tblSlot[k] < 0) ? 1 : 2) || seenStb !== expStb) begin
                nMiscompares++;
                if (latency == 0) expQ.delete();
                $display("[TB] FAIL b2b_route[%0d]: got latency=%0d stb=%b want latency=%0d stb=%b",
                         k, latency, seenStb, (tblSlot[k] < 0) ? 1 : 2, expStb);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
